// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer for a tapped-delay-line TDC.
// Detects a rising edge on the first tap, latches the coarse clock count and
// the tap vector, encodes the fine code as a popcount and presents the result
// on a valid/ready stream. A dead-time window follows every handshake. Hits
// that arrive while the sequencer is busy are counted in a saturating counter.
module tdc_meas_ctrl #(
    parameter int NTAPS       = 12,
    parameter int FINE_W      = 4,
    parameter int COARSE_W    = 16,
    parameter int DEAD_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                arm,
    input  logic                cont,
    input  logic [NTAPS-1:0]    taps,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [COARSE_W-1:0] m_coarse,
    output logic [FINE_W-1:0]   m_fine,
    output logic                m_sat,
    output logic                busy,
    output logic [7:0]          lost_cnt
);

    localparam int DCNT_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DCNT_W-1:0] DEAD_LAST = DCNT_W'(DEAD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_ENCODE,
        S_HOLD,
        S_DEAD
    } state_t;

    state_t              state;
    logic [COARSE_W-1:0] coarse_cnt;
    logic                taps0_q;
    logic                hit_det;
    logic [NTAPS-1:0]    cap_taps;
    logic [COARSE_W-1:0] cap_coarse;
    logic [DCNT_W-1:0]   dead_cnt;

    // Counts every tap that is set; bubbles in the thermometer code are not corrected.
    function automatic logic [FINE_W-1:0] popcount(input logic [NTAPS-1:0] v);
        logic [FINE_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < NTAPS; i++) begin
            n = n + FINE_W'(v[i]);
        end
        return n;
    endfunction

    assign hit_det = taps[0] & ~taps0_q;
    assign busy    = (state == S_ENCODE) || (state == S_HOLD) || (state == S_DEAD);

    // Free-running coarse time base, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) coarse_cnt <= '0;
        else        coarse_cnt <= coarse_cnt + 1'b1;
    end

    // Previous first-tap value for rising-edge hit detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) taps0_q <= 1'b0;
        else        taps0_q <= taps[0];
    end

    // Hits arriving while busy are lost; counter sticks at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lost_cnt <= '0;
        end else if (hit_det && busy && (lost_cnt != 8'hFF)) begin
            lost_cnt <= lost_cnt + 8'd1;
        end
    end

    // Sequencer: capture, encode, hold result until accepted, then dead time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cap_taps   <= '0;
            cap_coarse <= '0;
            dead_cnt   <= '0;
            m_valid    <= 1'b0;
            m_coarse   <= '0;
            m_fine     <= '0;
            m_sat      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arm) state <= S_ARMED;
                end
                S_ARMED: begin
                    if (!arm) begin
                        state <= S_IDLE;
                    end else if (hit_det) begin
                        cap_taps   <= taps;
                        cap_coarse <= coarse_cnt;
                        state      <= S_ENCODE;
                    end
                end
                S_ENCODE: begin
                    m_fine   <= popcount(cap_taps);
                    m_sat    <= &cap_taps;
                    m_coarse <= cap_coarse;
                    m_valid  <= 1'b1;
                    state    <= S_HOLD;
                end
                S_HOLD: begin
                    if (m_ready) begin
                        m_valid  <= 1'b0;
                        dead_cnt <= '0;
                        state    <= S_DEAD;
                    end
                end
                S_DEAD: begin
                    // Counter parks at its last value so a stuck first tap
                    // keeps the exit condition pending until the tap drops.
                    if (dead_cnt == DEAD_LAST) begin
                        if (!taps[0]) state <= (arm && cont) ? S_ARMED : S_IDLE;
                    end else begin
                        dead_cnt <= dead_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Self-checking bench for tdc_meas_ctrl: directed scenarios plus randomized
// transactions, checked against expectations derived from timing rules.
module tb_tdc_meas_ctrl;

    localparam int DEAD = 4;

    logic        clk;
    logic        rst_n;
    logic        arm;
    logic        cont;
    logic [11:0] taps;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_coarse;
    logic [3:0]  m_fine;
    logic        m_sat;
    logic        busy;
    logic [7:0]  lost_cnt;

    int          checks   = 0;
    int          failures = 0;
    int          lost_m   = 0;
    logic [15:0] cc_m;

    tdc_meas_ctrl #(
        .NTAPS      (12),
        .FINE_W     (4),
        .COARSE_W   (16),
        .DEAD_CYCLES(DEAD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .arm     (arm),
        .cont    (cont),
        .taps    (taps),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_coarse(m_coarse),
        .m_fine  (m_fine),
        .m_sat   (m_sat),
        .busy    (busy),
        .lost_cnt(lost_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference time base: cycles since reset release, modulo 2**16.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cc_m <= 16'd0;
        else        cc_m <= cc_m + 16'd1;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    // One measurement from hit to end of dead time. Caller guarantees ARMED
    // state and taps[0] low on the previous edge. k = extra hits during HOLD,
    // rdly = extra HOLD cycles, dpath = hit during dead time held for s extra cycles.
    task automatic measure(input logic [11:0] tv, input int k, input int rdly,
                           input bit dpath, input int s);
        logic [15:0] ec;
        logic [3:0]  ef;
        logic        es;
        int          exit_rel;
        bit          one;
        taps = tv;
        ec   = cc_m;
        ef   = 4'($countones(tv));
        es   = (tv == 12'hFFF);
        step();
        chk("enc_valid", m_valid, 0);
        chk("enc_busy", busy, 1);
        step();
        chk("hold_valid", m_valid, 1);
        chk("hold_coarse", m_coarse, ec);
        chk("hold_fine", m_fine, ef);
        chk("hold_sat", m_sat, es);
        chk("hold_busy", busy, 1);
        for (int i = 0; i < k; i++) begin
            taps = 12'h000;
            step();
            taps = tv;
            step();
            lost_m = sat_inc(lost_m);
            chk("hold_lost", lost_cnt, lost_m);
            chk("hold_stable_v", m_valid, 1);
            chk("hold_stable_c", m_coarse, ec);
            chk("hold_stable_f", m_fine, ef);
        end
        for (int i = 0; i < rdly; i++) begin
            step();
            chk("wait_valid", m_valid, 1);
            chk("wait_coarse", m_coarse, ec);
            chk("wait_fine", m_fine, ef);
        end
        m_ready = 1'b1;
        taps    = 12'h000;
        step();
        m_ready = 1'b0;
        chk("hs_valid", m_valid, 0);
        chk("hs_busy", busy, 1);
        // Exit edge: no earlier than DEAD after handshake, and not while tap 0 is high.
        exit_rel = DEAD;
        if (dpath && (3 + s > DEAD)) exit_rel = 3 + s;
        for (int r = 1; r <= exit_rel; r++) begin
            one  = dpath && (r >= 2) && (r <= 2 + s);
            taps = one ? 12'h001 : 12'h000;
            if (dpath && r == 2) lost_m = sat_inc(lost_m);
            step();
            chk("dead_busy", busy, (r < exit_rel) ? 1 : 0);
            chk("dead_lost", lost_cnt, lost_m);
        end
    endtask

    initial begin
        logic [11:0] tv;
        logic [11:0] all1;
        int          guard;

        all1    = 12'hFFF;
        rst_n   = 1'b0;
        arm     = 1'b0;
        cont    = 1'b0;
        taps    = 12'h000;
        m_ready = 1'b0;
        #2;
        chk("rst_valid", m_valid, 0);
        chk("rst_coarse", m_coarse, 0);
        chk("rst_fine", m_fine, 0);
        chk("rst_sat", m_sat, 0);
        chk("rst_busy", busy, 0);
        chk("rst_lost", lost_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) step();
        chk("idle_busy", busy, 0);
        chk("idle_valid", m_valid, 0);

        // Test 1: capture at coarse 100, single-shot.
        arm = 1'b1;
        guard = 0;
        while (cc_m != 16'd100 && guard < 1000) begin
            step();
            guard++;
        end
        chk("t1_reach100", cc_m, 100);
        measure(12'h007, 0, 2, 1'b0, 0);
        // Single-shot returns to IDLE: a hit now only re-arms, is not captured or counted.
        taps = 12'h001;
        step();
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_lost", lost_cnt, lost_m);
        step();
        chk("t1_idle_valid", m_valid, 0);
        step();
        chk("t1_idle_valid2", m_valid, 0);
        chk("t1_idle_busy2", busy, 0);
        taps = 12'h000;
        step();

        // Test 2: saturated chain.
        measure(12'hFFF, 0, 1, 1'b0, 0);
        step();

        // Randomized transactions.
        for (int n = 0; n < 24; n++) begin
            cont = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) tv = all1 >> $urandom_range(0, 11);
            else                           tv = 12'($urandom) | 12'h001;
            measure(tv, $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), $urandom_range(0, 3));
            step();
        end

        // Test 3: continuous mode, 3 hits during a 10-cycle HOLD, then next hit captured.
        cont = 1'b1;
        measure(12'h01F, 3, 4, 1'b0, 0);
        measure(12'h003, 0, 0, 1'b0, 0);
        step();

        // Test 6b: first tap stuck high through dead time.
        measure(12'h07F, 0, 0, 1'b1, 6);
        step();

        // Test 5: disarm coincides with hit.
        arm  = 1'b0;
        taps = 12'h001;
        step();
        chk("t5_busy", busy, 0);
        chk("t5_lost", lost_cnt, lost_m);
        step();
        chk("t5_valid", m_valid, 0);
        arm = 1'b1;
        step();
        step();
        chk("t5_valid2", m_valid, 0);
        chk("t5_busy2", busy, 0);
        taps = 12'h000;
        step();

        // Lost counter saturation.
        measure(12'h00F, 260, 0, 1'b0, 0);
        chk("lost_sat", lost_cnt, 255);
        step();

        // Test 6a: asynchronous reset while holding a result.
        taps = 12'h0FF;
        step();
        step();
        chk("pre_rst_valid", m_valid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        lost_m = 0;
        chk("arst_valid", m_valid, 0);
        chk("arst_lost", lost_cnt, 0);
        chk("arst_busy", busy, 0);
        chk("arst_coarse", m_coarse, 0);
        chk("arst_fine", m_fine, 0);
        taps = 12'h000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        arm   = 1'b1;
        cont  = 1'b1;
        step();
        chk("post_rst_valid", m_valid, 0);

        // Test 4: capture at the last coarse value, then one right after re-arm.
        guard = 0;
        while (cc_m != 16'hFFFF && guard < 70000) begin
            step();
            guard++;
        end
        chk("t4_reach_ffff", cc_m, 16'hFFFF);
        measure(12'h3FF, 0, 0, 1'b0, 0);
        measure(12'h001, 0, 0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
